// File: rtl/sseg_scan_if.sv
// sseg_scan_if: data inputs and anode/segment outputs of the seven-segment scanner
interface sseg_scan_if #(
  parameter int NUM_DISPLAYS = 2,
  parameter int DIGITS_PER_DISP = 4,
  parameter int PWM_BITS = 4
);
  localparam int N = NUM_DISPLAYS * DIGITS_PER_DISP;
  logic [7*N-1:0] hex;
  logic [N-1:0] dpoints;
  logic [N-1:0] digit_en;
  logic [N-1:0] blink;
  logic [PWM_BITS-1:0] brightness;
  logic [N-1:0] an;
  logic [8*NUM_DISPLAYS-1:0] seg;
  logic frame_tick;
  modport master (
    output hex, dpoints, digit_en, blink, brightness,
    input an, seg, frame_tick
  );
  modport slave (
    input hex, dpoints, digit_en, blink, brightness,
    output an, seg, frame_tick
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: multi-display seven-segment scanner with PWM, blink, blanking and frame-latched data
module sseg_scan_driver #(
  parameter int NUM_DISPLAYS = 2,
  parameter int DIGITS_PER_DISP = 4,
  parameter int CNT_LIMIT = 100000,
  parameter int PWM_BITS = 4,
  parameter int BLINK_FRAMES = 128
) (
  input logic clk,
  input logic reset,
  sseg_scan_if.slave bus
);
  localparam int N = NUM_DISPLAYS * DIGITS_PER_DISP;
  localparam int CW = $clog2(CNT_LIMIT);
  localparam int IW = $clog2(DIGITS_PER_DISP);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [CW-1:0] cycle_cnt;
  logic [IW-1:0] idx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BW-1:0] blink_cnt;
  logic blink_phase, first_frame, tick_q;
  logic slot_end, last_slot, frame_start, blink_wrap, lit;
  logic [7*N-1:0] hex_s, hex_e;
  logic [N-1:0] dp_s, en_s, bl_s, dp_e, en_e, bl_e, an_n, an_q;
  logic [8*NUM_DISPLAYS-1:0] seg_n, seg_q;
  assign slot_end = cycle_cnt == CW'(CNT_LIMIT - 1);
  assign last_slot = idx == IW'(DIGITS_PER_DISP - 1);
  assign frame_start = idx == '0 && cycle_cnt == '0;
  assign blink_wrap = blink_cnt == BW'(BLINK_FRAMES - 1);
  assign lit = pwm_cnt < bus.brightness;
  // the frame's first cycle already shows the data being latched
  assign hex_e = frame_start ? bus.hex : hex_s;
  assign dp_e = frame_start ? bus.dpoints : dp_s;
  assign en_e = frame_start ? bus.digit_en : en_s;
  assign bl_e = frame_start ? bus.blink : bl_s;
  for (genvar d = 0; d < NUM_DISPLAYS; d++) begin : g_disp
    logic [6:0] hx [DIGITS_PER_DISP];
    logic [DIGITS_PER_DISP-1:0] en, bl, dp;
    logic show;
    for (genvar k = 0; k < DIGITS_PER_DISP; k++) begin : g_dig
      assign hx[k] = hex_e[7*(d*DIGITS_PER_DISP+k) +: 7];
    end
    assign en = en_e[d*DIGITS_PER_DISP +: DIGITS_PER_DISP];
    assign bl = bl_e[d*DIGITS_PER_DISP +: DIGITS_PER_DISP];
    assign dp = dp_e[d*DIGITS_PER_DISP +: DIGITS_PER_DISP];
    assign show = en[idx] && !(bl[idx] && blink_phase) && lit;
    assign an_n[d*DIGITS_PER_DISP +: DIGITS_PER_DISP] = show ? ~(DIGITS_PER_DISP'(1) << idx) : '1;
    assign seg_n[8*d +: 8] = show ? {~dp[idx], hx[idx]} : 8'hFF;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      idx <= '0;
      pwm_cnt <= '0;
      blink_cnt <= '0;
      blink_phase <= 1'b0;
      first_frame <= 1'b1;
      hex_s <= '1;
      dp_s <= '0;
      en_s <= '0;
      bl_s <= '0;
      an_q <= '1;
      seg_q <= '1;
      tick_q <= 1'b0;
    end else begin
      cycle_cnt <= slot_end ? '0 : cycle_cnt + 1'b1;
      pwm_cnt <= slot_end ? '0 : pwm_cnt + 1'b1;
      if (slot_end) idx <= last_slot ? '0 : idx + 1'b1;
      if (slot_end && last_slot) begin
        blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
        blink_phase <= blink_phase ^ blink_wrap;
      end
      if (frame_start) begin
        first_frame <= 1'b0;
        hex_s <= bus.hex;
        dp_s <= bus.dpoints;
        en_s <= bus.digit_en;
        bl_s <= bus.blink;
      end
      an_q <= an_n;
      seg_q <= seg_n;
      tick_q <= frame_start && !first_frame;
    end
  end
  assign bus.an = an_q;
  assign bus.seg = seg_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: directed plus random scan checks against a time-based reference model
module tb_sseg_scan_driver;
  localparam int CNT = 4;
  localparam int BF = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [55:0] hex;
  logic [7:0] dp, en, bl;
  logic [1:0] br;
  int vectors = 0;
  int miscompares = 0;
  int ta = 0;
  int tb = 0;
  logic [55:0] sa_hex, sb_hex;
  logic [7:0] sa_dp, sa_en, sa_bl, sb_dp, sb_en, sb_bl;
  always #5 clk = ~clk;
  sseg_scan_if #(.NUM_DISPLAYS(2), .DIGITS_PER_DISP(4), .PWM_BITS(2)) ia ();
  sseg_scan_if #(.NUM_DISPLAYS(2), .DIGITS_PER_DISP(3), .PWM_BITS(2)) ib ();
  assign ia.hex = hex;
  assign ia.dpoints = dp;
  assign ia.digit_en = en;
  assign ia.blink = bl;
  assign ia.brightness = br;
  assign ib.hex = hex[41:0];
  assign ib.dpoints = dp[5:0];
  assign ib.digit_en = en[5:0];
  assign ib.blink = bl[5:0];
  assign ib.brightness = br;
  sseg_scan_driver #(.NUM_DISPLAYS(2), .DIGITS_PER_DISP(4), .CNT_LIMIT(CNT), .PWM_BITS(2), .BLINK_FRAMES(BF))
    dut_a (.clk(clk), .reset(reset), .bus(ia));
  sseg_scan_driver #(.NUM_DISPLAYS(2), .DIGITS_PER_DISP(3), .CNT_LIMIT(CNT), .PWM_BITS(2), .BLINK_FRAMES(BF))
    dut_b (.clk(clk), .reset(reset), .bus(ib));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, ta);
    end
  endtask

  // expected outputs for the state t cycles after reset, from slot/frame arithmetic
  function automatic void model(input int t, input int dpd, input logic [55:0] h,
                                input logic [7:0] dv, input logic [7:0] ev, input logic [7:0] bv,
                                input logic [1:0] b, output logic [7:0] an, output logic [15:0] sg);
    int cc, ix, p;
    bit ph, lit;
    logic [55:0] hs;
    logic [7:0] e, k, dd;
    cc = t % CNT;
    ix = (t / CNT) % dpd;
    ph = ((t / (CNT * dpd)) / BF) % 2 == 1;
    lit = (cc % 4) < int'(b);
    an = '1;
    sg = '1;
    for (int d = 0; d < 2; d++) begin
      p = d * dpd + ix;
      hs = h >> (7 * p);
      e = ev >> p;
      k = bv >> p;
      dd = dv >> p;
      if (e[0] && !(k[0] && ph) && lit) begin
        an = an & ~(8'd1 << p);
        sg = (sg & ~(16'hFF << (8 * d))) | (16'({~dd[0], hs[6:0]}) << (8 * d));
      end
    end
  endfunction

  task automatic step();
    logic [7:0] ea, eb;
    logic [15:0] sga, sgb;
    logic tka, tkb;
    if (reset) begin
      ea = '1; eb = '1; sga = '1; sgb = '1; tka = 1'b0; tkb = 1'b0;
    end else begin
      if (ta % (CNT * 4) == 0) {sa_hex, sa_dp, sa_en, sa_bl} = {hex, dp, en, bl};
      if (tb % (CNT * 3) == 0) {sb_hex, sb_dp, sb_en, sb_bl} = {hex, dp, en, bl};
      model(ta, 4, sa_hex, sa_dp, sa_en, sa_bl, br, ea, sga);
      model(tb, 3, sb_hex, sb_dp, sb_en, sb_bl, br, eb, sgb);
      tka = ta % (CNT * 4) == 0 && ta != 0;
      tkb = tb % (CNT * 3) == 0 && tb != 0;
    end
    @(posedge clk);
    #1;
    chk("an_a", 64'(ia.an), 64'(ea));
    chk("seg_a", 64'(ia.seg), 64'(sga));
    chk("tick_a", 64'(ia.frame_tick), 64'(tka));
    chk("onehot_a", 64'($countones(~ia.an[3:0]) <= 1 && $countones(~ia.an[7:4]) <= 1), 64'd1);
    chk("an_b", 64'(ib.an), 64'(eb[5:0]));
    chk("seg_b", 64'(ib.seg), 64'(sgb));
    chk("tick_b", 64'(ib.frame_tick), 64'(tkb));
    if (reset) begin
      ta = 0; tb = 0;
    end else begin
      ta++; tb++;
    end
  endtask

  initial begin
    hex = '0;
    for (int i = 0; i < 8; i++) hex = hex | (56'(i) << (7 * i));
    dp = '0; en = '1; bl = '0; br = 2'd3;
    repeat (3) step();
    reset = 1'b0;
    repeat (32) step();
    br = 2'd1;
    repeat (16) step();
    br = 2'd0;
    repeat (16) step();
    br = 2'd3;
    hex = {hex[55:7], 7'h40};
    repeat (22) step();
    hex = {hex[55:7], 7'h79};
    repeat (26) step();
    dp = 8'h80;
    repeat (16) step();
    dp = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bl = 8'h01; en = 8'hFE;
    repeat (96) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    en = 8'hFF;
    repeat (96) step();
    bl = '0;
    for (int i = 0; i < 16 && (ta / CNT) % 4 != 2; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (24) step();
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        hex = 56'({$urandom(), $urandom()});
        dp = 8'($urandom());
        en = 8'($urandom());
        bl = 8'($urandom());
      end
      if ($urandom_range(0, 7) == 0) br = 2'($urandom());
      reset = $urandom_range(0, 99) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Parametrised successor to the fixed 2x4-digit seven-segment scanner.
- Time-multiplexes NUM_DISPLAYS displays of DIGITS_PER_DISP digits each. Adds per-digit blanking, per-digit blink, PWM brightness, frame-latched (tear-free) input data and a frame tick.
- Sits between the character/segment encoders and the board's anode/segment pins.

Parameters:
- NUM_DISPLAYS, 2: number of physical display modules. Each has its own anode bus and segment bus.
- DIGITS_PER_DISP, 4: digits per module. Must be ≥2.
- CNT_LIMIT, 100000: clocks each digit slot lasts. Must be ≥2. At 100 MHz the default gives 1 ms per slot.
- PWM_BITS, 4: brightness resolution.
- BLINK_FRAMES, 128: full scan frames per blink half-period. Must be ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- hex  in  NUM_DISPLAYS*DIGITS_PER_DISP*7  active-low segment patterns {g..a}. Digit i = display i/DIGITS_PER_DISP, position i%DIGITS_PER_DISP; occupies bits [7i+6:7i].
- dpoints  in  N=NUM_DISPLAYS*DIGITS_PER_DISP  active-high decimal point per digit
- digit_en  in  N  1 = digit shown, 0 = digit blanked
- blink  in  N  1 = digit blinks
- brightness  in  PWM_BITS  duty = brightness/2^PWM_BITS. 0 = dark.
- an  out  N  active-low anodes. Bit d*DIGITS_PER_DISP+k drives display d, position k.
- seg  out  NUM_DISPLAYS*8  active-low {dp,g..a}. Display d occupies bits [8d+7:8d].
- frame_tick  out  1  one-cycle pulse at start of each frame after the first

Behaviour:
- Reset (synchronous, active-high):
  - an = all 1s, seg = all 1s, frame_tick = 0.
  - cycle_cnt = 0, idx = 0, pwm_cnt = 0, blink_cnt = 0, blink_phase = 0.
  - Shadow registers (hex/dpoints/digit_en/blink) = blank: hex all 1s, dpoints 0, digit_en 0, blink 0.
- cycle_cnt counts 0..CNT_LIMIT-1 and wraps to 0. slot_end = (cycle_cnt == CNT_LIMIT-1).
- idx (width clog2(DIGITS_PER_DISP)) increments on slot_end and wraps DIGITS_PER_DISP-1 → 0. One slot = CNT_LIMIT clocks; one frame = DIGITS_PER_DISP*CNT_LIMIT clocks.
- frame_start = (idx == 0 && cycle_cnt == 0). This is true on the first cycle after reset and on the first cycle of every frame.
- Shadow load: on frame_start the shadow registers load from hex/dpoints/digit_en/blink. Input changes at any other time do not appear until the next frame.
- pwm_cnt (PWM_BITS wide) clears to 0 when cycle_cnt == 0, otherwise increments mod 2^PWM_BITS.
- Digit lit = (pwm_cnt < brightness). brightness is sampled live each cycle, not frame-latched.
- Blink timing:
  - On the last cycle of each frame (slot_end && idx == DIGITS_PER_DISP-1), blink_cnt increments.
  - When blink_cnt reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- Per display d, at position p = d*DIGITS_PER_DISP + idx, the effective data source is the live inputs on a frame_start cycle and the shadow registers otherwise.
- show = en_eff[p] && !(blink_eff[p] && blink_phase) && lit.
- Registered outputs, 1-cycle latency from counter state:
  - If show: an bit p = 0 and all other an bits of display d = 1; seg[d] = {~dp_eff[p], hex_eff[p]}.
  - Else: all an bits of display d = 1 and seg[d] = 8'hFF.
- frame_tick is registered: high on exactly the cycles where frame_start is true, excluding the first frame after reset.
- Boundary conditions:
  - brightness == 2^PWM_BITS-1 gives (2^PWM_BITS-1)/2^PWM_BITS duty, never 100%.
  - brightness == 0: an stays all 1s.
  - At most one an bit per display is low in any cycle, and exactly one position is selected per display.
  - Reset asserted mid-frame returns everything to reset values on the next edge. The first post-reset frame starts with idx = 0.
- Non-power-of-two DIGITS_PER_DISP: idx must never exceed DIGITS_PER_DISP-1.

Test Plan:
(All scenarios use NUM_DISPLAYS=2, DIGITS_PER_DISP=4, CNT_LIMIT=4, PWM_BITS=2, BLINK_FRAMES=2 unless stated.)
- Reset/scan: hold reset 3 cycles, digit_en=8'hFF, brightness=3, hex digit i = 7'(i) → an=8'hFF and seg=16'hFFFF during reset.
  - Afterwards an[3:0] steps 1110→1101→1011→0111 every 4 clocks and each lit cycle shows seg[7:0]={1,7'(k)}.
  - Only pwm_cnt 0..2 are lit (3 of 4 clocks).
- Brightness: brightness=1 → each slot is lit exactly 1 clock (cycle_cnt=0, output the next cycle). brightness=0 → an stays 8'hFF for a full frame.
- Frame latch: change hex[6:0] from 7'h40 to 7'h79 mid-frame → seg[6:0] stays 7'h40 until the first digit-0 slot of the next frame, then shows 7'h79. frame_tick pulses once per 16 clocks, none in the first frame.
- Blink/blank: blink=8'h01, digit_en=8'hFE → digit 0 is always dark. Repeat with digit_en=8'hFF: digit 0 is lit in frames 0-1, dark in frames 2-3, lit in frames 4-5. Digits 1-7 are unaffected throughout.
- Dp/second display: dpoints=8'h80 → seg[15] = 0 only during idx=3 lit cycles; seg[7] is always 1.
- Reset mid-operation: assert reset during idx=2 → next cycle has an=8'hFF, and scanning restarts at idx=0 with shadow reloaded on frame_start.
- DIGITS_PER_DISP=3 variant → idx sequence 0,1,2,0. an[3] (the display-1 anode) behaves as position 0 of display 1.
